plic: RTL and testbench

PLIC -- requirements
Module: plic

---
 rtl/plic.sv | 219 +++++++++++++++++++++
 tb/tb_plic.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic.sv
// ---------------------------------------------------------------------------
// plic -- platform-level interrupt controller, single machine-mode context.
//
// Collects level-sensitive interrupt lines through a per-source gateway
// (pending/inflight), arbitrates by priority against a threshold and exposes
// a claim/complete register.  The register file sits behind a simple
// valid/ready bus that answers every request exactly one cycle later.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   plic_valid   request strobe (every valid cycle is accepted)
//   plic_instr   request is an instruction fetch (answered with 0, no effect)
//   plic_addr    byte offset from PLIC base; addr[1:0] ignored
//   plic_wdata   write data
//   plic_wstrb   byte write strobes; 0 means read
//   plic_rdata   read data, 0 whenever plic_ready is low
//   plic_ready   one-cycle response strobe
//   plic_src     interrupt lines, bit 0 ignored
//   plic_meip    registered external-interrupt-pending output
//
// Register map (word addresses):
//   0x000000+4*i priority[i]   0x001000 pending (RO)   0x002000 enable
//   0x200000 threshold         0x200004 claim (read) / complete (write)
// ---------------------------------------------------------------------------
module plic #(
    parameter int plic_sources   = 8,
    parameter int plic_prio_bits = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    plic_valid,
    input  logic                    plic_instr,
    input  logic [31:0]             plic_addr,
    input  logic [31:0]             plic_wdata,
    input  logic [3:0]              plic_wstrb,
    output logic [31:0]             plic_rdata,
    output logic                    plic_ready,
    input  logic [plic_sources-1:0] plic_src,
    output logic                    plic_meip
);

    localparam int NS  = plic_sources;
    localparam int PB  = plic_prio_bits;
    localparam int IDW = $clog2(NS);
    localparam logic [31:0] NUM_SRC = plic_sources;
    // Source 0 does not exist, so its enable bit is hard-wired to zero.
    localparam logic [NS-1:0] EN_MASK = {{(NS-1){1'b1}}, 1'b0};

    // Replace the strobed bytes of a zero-extended register image.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        req;
    logic        is_write;
    logic        is_read;
    logic [29:0] word_addr;
    logic [9:0]  prio_idx;
    logic        hit_prio;
    logic        hit_pend;
    logic        hit_en;
    logic        hit_thr;
    logic        hit_claim;

    assign req       = plic_valid & ~plic_instr;
    assign is_write  = req & (|plic_wstrb);
    assign is_read   = req & ~(|plic_wstrb);
    assign word_addr = plic_addr[31:2];
    assign prio_idx  = plic_addr[11:2];
    assign hit_prio  = (plic_addr[31:12] == 20'd0) && ({22'd0, prio_idx} < NUM_SRC);
    assign hit_pend  = (word_addr == 30'h0000400);
    assign hit_en    = (word_addr == 30'h0000800);
    assign hit_thr   = (word_addr == 30'h0080000);
    assign hit_claim = (word_addr == 30'h0080001);

    // Byte lanes below the word and source 0 carry no information.
    logic unused_bits;
    assign unused_bits = ^{plic_addr[1:0], plic_src[0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NS-1:0]    enable_reg;
    logic [PB-1:0]    thr_reg;
    logic [NS-1:0]    pending_reg;
    logic [NS-1:0]    inflight_reg;
    logic             ready_reg;
    logic [31:0]      rdata_reg;
    logic             meip_reg;

    logic [NS*PB-1:0] prio_flat;
    logic [NS-1:0]    pending_next;
    logic [NS-1:0]    inflight_next;
    logic [NS-1:0]    eligible;
    logic [NS-1:0]    claim_hit;
    logic [NS-1:0]    complete_hit;
    logic [IDW-1:0]   claim_id;
    logic [31:0]      rdata_next;

    // ------------------------------------------------------------------
    // Claim selection: scanning upward with a strict '>' keeps the lowest
    // ID on ties; starting from the threshold enforces prio > threshold
    // and makes priority-0 sources unclaimable.
    // ------------------------------------------------------------------
    logic [PB-1:0] best_prio;

    always_comb begin
        claim_id  = '0;
        best_prio = thr_reg;
        for (int i = 1; i < NS; i++) begin
            if (pending_reg[i] && enable_reg[i] && (prio_flat[i*PB +: PB] > best_prio)) begin
                best_prio = prio_flat[i*PB +: PB];
                claim_id  = IDW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-source priority register and gateway
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NS; gi++) begin : gen_src
        if (gi == 0) begin : gen_none
            assign prio_flat[PB-1:0] = '0;
            assign pending_next[0]   = 1'b0;
            assign inflight_next[0]  = 1'b0;
            assign eligible[0]       = 1'b0;
            assign claim_hit[0]      = 1'b0;
            assign complete_hit[0]   = 1'b0;
        end else begin : gen_real
            logic [PB-1:0] prio_reg;
            logic          prio_sel;

            assign prio_sel = is_write & hit_prio & (prio_idx == 10'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prio_reg <= '0;
                end else if (prio_sel) begin
                    prio_reg <= PB'(merge_bytes(32'(prio_reg), plic_wdata, plic_wstrb));
                end
            end

            assign prio_flat[gi*PB +: PB] = prio_reg;
            assign claim_hit[gi]    = is_read & hit_claim & (claim_id == IDW'(gi));
            assign complete_hit[gi] = is_write & hit_claim & (plic_wdata == 32'(gi))
                                      & inflight_reg[gi];
            assign eligible[gi]     = pending_reg[gi] & enable_reg[gi] & (prio_reg > thr_reg);
            // Inflight blocks re-pending, so a claim coinciding with an
            // active line leaves pending clear, and a complete only lets the
            // line re-pend on the edge after it has taken effect.
            assign pending_next[gi]  = (pending_reg[gi] | (plic_src[gi] & ~inflight_reg[gi]))
                                       & ~claim_hit[gi];
            assign inflight_next[gi] = (inflight_reg[gi] | claim_hit[gi]) & ~complete_hit[gi];
        end
    end

    // ------------------------------------------------------------------
    // Read data, captured at the request edge and shown in the response
    // cycle; writes, fetches and unmapped reads answer 0.
    // ------------------------------------------------------------------
    always_comb begin
        rdata_next = '0;
        if (is_read) begin
            if (hit_prio) begin
                for (int i = 0; i < NS; i++) begin
                    if (prio_idx == 10'(i)) rdata_next = 32'(prio_flat[i*PB +: PB]);
                end
            end else if (hit_pend) begin
                rdata_next = 32'(pending_reg);
            end else if (hit_en) begin
                rdata_next = 32'(enable_reg);
            end else if (hit_thr) begin
                rdata_next = 32'(thr_reg);
            end else if (hit_claim) begin
                rdata_next = 32'(claim_id);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_reg   <= '0;
            thr_reg      <= '0;
            pending_reg  <= '0;
            inflight_reg <= '0;
            ready_reg    <= 1'b0;
            rdata_reg    <= '0;
            meip_reg     <= 1'b0;
        end else begin
            ready_reg    <= plic_valid;
            rdata_reg    <= rdata_next;
            meip_reg     <= |eligible;
            pending_reg  <= pending_next;
            inflight_reg <= inflight_next;
            if (is_write && hit_en) begin
                enable_reg <= NS'(merge_bytes(32'(enable_reg), plic_wdata, plic_wstrb)) & EN_MASK;
            end
            if (is_write && hit_thr) begin
                thr_reg <= PB'(merge_bytes(32'(thr_reg), plic_wdata, plic_wstrb));
            end
        end
    end

    assign plic_ready = ready_reg;
    assign plic_rdata = rdata_reg;
    assign plic_meip  = meip_reg;

endmodule

// File: tb/tb_plic.sv
// ---------------------------------------------------------------------------
// tb_plic -- self-checking bench for plic (8 sources, 3-bit priority).
// A cycle-level reference model of the register map, gateway and arbiter
// predicts ready/rdata/meip for every clock; directed steps add literal
// expectations, followed by a randomized bus/interrupt phase.
// ---------------------------------------------------------------------------
module tb_plic;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        instr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [7:0]  src = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        meip;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_prio [NS];
    logic [7:0]  m_en;
    int          m_thr;
    logic [7:0]  m_pend;
    logic [7:0]  m_infl;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_meip;

    plic #(.plic_sources(NS), .plic_prio_bits(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .plic_valid (valid),
        .plic_instr (instr),
        .plic_addr  (addr),
        .plic_wdata (wdata),
        .plic_wstrb (wstrb),
        .plic_rdata (rdata),
        .plic_ready (ready),
        .plic_src   (src),
        .plic_meip  (meip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_val[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_prio[i] = 0;
        m_en = '0; m_thr = 0; m_pend = '0; m_infl = '0;
        m_ready = 1'b0; m_rdata = '0; m_meip = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held now.
    task automatic model_step();
        int          maxp;
        int          id;
        bit          any;
        logic [7:0]  npend;
        logic [7:0]  ninfl;
        logic [31:0] a;
        int          idx;
        int          w;
        bit          elig [NS];
        any  = 0;
        maxp = -1;
        id   = 0;
        for (int i = 0; i < NS; i++) begin
            elig[i] = (i != 0) && m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
            if (elig[i]) begin
                any = 1;
                if (m_prio[i] > maxp) maxp = m_prio[i];
            end
        end
        // Among the highest-priority candidates take the smallest ID.
        for (int i = NS - 1; i >= 1; i--) if (elig[i] && m_prio[i] == maxp) id = i;

        npend    = (m_pend | (src & ~m_infl)) & 8'hFE;
        ninfl    = m_infl;
        m_ready  = valid;
        m_rdata  = '0;
        if (valid && !instr) begin
            a = addr & 32'hFFFF_FFFC;
            if (a < 32'h1000 && (a >> 2) < NS) begin
                idx = int'(a >> 2);
                if (wstrb == 0) m_rdata = 32'(m_prio[idx]);
                else if (idx != 0) m_prio[idx] = int'(merge(32'(m_prio[idx]), wdata, wstrb) & 32'h7);
            end else if (a == 32'h1000) begin
                if (wstrb == 0) m_rdata = 32'(m_pend);
            end else if (a == 32'h2000) begin
                if (wstrb == 0) m_rdata = 32'(m_en);
                else m_en = merge(32'(m_en), wdata, wstrb) & 8'hFE;
            end else if (a == 32'h200000) begin
                if (wstrb == 0) m_rdata = 32'(m_thr);
                else m_thr = int'(merge(32'(m_thr), wdata, wstrb) & 32'h7);
            end else if (a == 32'h200004) begin
                if (wstrb == 0) begin
                    m_rdata = 32'(id);
                    if (id != 0) begin
                        npend[id] = 1'b0;
                        ninfl[id] = 1'b1;
                    end
                end else if (wdata > 0 && wdata < NS) begin
                    w = int'(wdata);
                    if (m_infl[w]) ninfl[w] = 1'b0;
                end
            end
        end
        m_meip = any;
        m_pend = npend;
        m_infl = ninfl;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ready", 32'(ready), 32'(m_ready));
        chk("rdata", rdata, m_rdata);
        chk("meip", 32'(meip), 32'(m_meip));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic op(input logic ins, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        valid = 1'b1; instr = ins; addr = a; wdata = d; wstrb = s;
        tick();
        valid = 1'b0; instr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        op(1'b0, a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        op(1'b0, a, 32'h0, 4'h0);
        chk(tag, rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_meip", 32'(meip), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();
        rd(32'h2000, 32'h0, "reset_enable");
        rd(32'h200000, 32'h0, "reset_thr");
        rd(32'h1000, 32'h0, "reset_pending");
        rd(32'h0C, 32'h0, "reset_prio3");

        // Priority versus threshold
        wr(32'h0C, 32'h5);
        wr(32'h2000, 32'h08);
        wr(32'h200000, 32'h4);
        src = 8'h08;
        idle(2);
        chk("meip_raised", 32'(meip), 32'h1);
        rd(32'h200004, 32'h3, "claim_3");
        idle(1);
        chk("meip_after_claim", 32'(meip), 32'h0);
        wr(32'h200000, 32'h5);
        wr(32'h200004, 32'h3);
        idle(2);
        rd(32'h200004, 32'h0, "claim_at_thr");
        rd(32'h0, 32'h0, "prio0_reads_0");
        wr(32'h0, 32'h7);
        rd(32'h0, 32'h0, "prio0_ignores_write");
        src = 8'h00;
        do_reset();

        // Arbitration: highest priority first, ties to lowest ID
        wr(32'h08, 32'h6);
        wr(32'h14, 32'h6);
        wr(32'h04, 32'h7);
        wr(32'h2000, 32'h26);
        src = 8'h26;
        idle(1);
        rd(32'h200004, 32'h1, "arb_first");
        rd(32'h200004, 32'h2, "arb_second");
        rd(32'h200004, 32'h5, "arb_third");
        rd(32'h200004, 32'h0, "arb_none");
        src = 8'h00;
        do_reset();

        // Complete while the line is still held; bogus complete
        wr(32'h0C, 32'h1);
        wr(32'h2000, 32'h08);
        src = 8'h08;
        idle(1);
        rd(32'h200004, 32'h3, "claim_held");
        wr(32'h200004, 32'h3);
        rd(32'h1000, 32'h0, "pend_same_cycle");
        rd(32'h1000, 32'h08, "pend_repended");
        src = 8'h00;
        wr(32'h200004, 32'h6);
        rd(32'h1000, 32'h08, "pend_after_bogus");

        // Handshake, unmapped and instruction-fetch accesses
        op(1'b0, 32'h2000, 32'h0, 4'h0);
        chk("b2b_ready_1", 32'(ready), 32'h1);
        op(1'b0, 32'h2000, 32'h0, 4'h0);
        chk("b2b_ready_2", 32'(ready), 32'h1);
        idle(1);
        chk("ready_idle", 32'(ready), 32'h0);
        chk("rdata_idle", rdata, 32'h0);
        rd(32'h3000, 32'h0, "unmapped");
        op(1'b1, 32'h200004, 32'h0, 4'h0);
        chk("instr_claim", rdata, 32'h0);
        rd(32'h1000, 32'h08, "pend_after_instr");

        // Byte strobes
        op(1'b0, 32'h2000, 32'hFFFF_FFFF, 4'h1);
        rd(32'h2000, 32'hFE, "enable_strobe");
        op(1'b0, 32'h0C, 32'hFFFF_FF00, 4'hE);
        rd(32'h0C, 32'h1, "prio_upper_strobes");
        op(1'b0, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h1000, 32'h08, "pend_readonly");

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            logic        ins;
            int          kind;
            if ($urandom_range(0, 5) == 0) src = 8'($urandom);
            kind = $urandom_range(0, 7);
            ins  = 1'b0;
            d    = $urandom;
            s    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            case (kind)
                0: a = 32'(4 * $urandom_range(0, 9) + $urandom_range(0, 3));
                1: a = 32'h1000;
                2: a = 32'h2000;
                3: a = 32'h200000;
                4: begin a = 32'h200004; s = 4'h0; end
                5: begin a = 32'h200004; s = 4'hF; d = 32'($urandom_range(0, 9)); end
                6: a = ($urandom_range(0, 1) == 0) ? 32'h3000 : 32'h200008;
                default: begin a = 32'h200004; ins = 1'b1; end
            endcase
            if ($urandom_range(0, 9) < 6) op(ins, a, d, s);
            else tick();
        end

        // Reset in the middle of a claim response
        src = 8'h00;
        do_reset();
        wr(32'h04, 32'h3);
        wr(32'h2000, 32'h02);
        src = 8'h02;
        idle(2);
        op(1'b0, 32'h200004, 32'h0, 4'h0);
        chk("claim_before_rst", rdata, 32'h1);
        src = 8'h00;
        #2;
        do_reset();
        rd(32'h2000, 32'h0, "post_rst_enable");
        rd(32'h04, 32'h0, "post_rst_prio1");
        rd(32'h1000, 32'h0, "post_rst_pending");
        rd(32'h200004, 32'h0, "post_rst_claim");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
